regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
//   Shares the single 32x32 register-file read port (5-bit address in, 32-bit data out) among NREQ requesters.
//   Round-robin grant, one request accepted per cycle, fully pipelined, fixed 2-cycle latency.
//   Forces reads of register 0 to zero and forwards a same-cycle register-file write to the read.
//   Sits between the requesting units (decode, debug) and the register-file read mux.
// PARAMETERS
//   NREQ  4  number of requesters, 2..8
//   IDW   2  requester-id width, >= clog2(NREQ)
// PORTS
//   clk        in   1         clock, all state on rising edge
//   rst_n      in   1         synchronous active-low reset
//   req_valid  in   NREQ      request i pending; held with req_addr until accepted
//   req_addr   in   5*NREQ    register address, requester i at [5i+4:5i]
//   req_ready  out  NREQ      one-hot grant, combinational; accept = valid & ready
//   rf_addr    out  5         registered address to register-file read mux
//   rf_data    in   32        combinational read data for rf_addr
//   wr_en      in   1         register-file write this cycle (snooped)
//   wr_addr    in   5         write address
//   wr_data    in   32        write data
//   rsp_valid  out  1         response valid, one-cycle pulse per accepted request
//   rsp_id     out  IDW       requester index of response
//   rsp_data   out  32        read result
//   busy       out  1         any request in flight (s1_valid | rsp_valid)
// BEHAVIOUR
//   Reset (rst_n=0 at edge): ptr=NREQ-1, s1_valid=0, rf_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0.
//   req_ready=0 while rst_n=0.
//   Arbitration (comb): search i = ptr+1, ptr+2, ... mod NREQ; first with req_valid[i] is granted.
//   - At most one req_ready bit high; req_ready=0 when no req_valid.
//   - On grant, ptr <= granted index; ptr unchanged when no grant.
//   Pipeline, request accepted in cycle T:
//   - Edge end of T: s1_valid<=1, s1_id<=index, rf_addr<=req_addr[index].
//   - No grant: s1_valid<=0, rf_addr holds its value.
//   - Cycle T+1: rf_data valid for rf_addr.
//     Edge end of T+1: rsp_valid<=s1_valid, rsp_id<=s1_id, rsp_data<=selected data.
//   - rsp_valid high in cycle T+2. Throughput 1/cycle, no backpressure; a consumer must always accept.
//   Data select at the S1->rsp edge, priority order:
//   - rf_addr==0 -> 32'h0 (even if wr_en && wr_addr==0).
//   - wr_en && wr_addr==rf_addr -> wr_data (bypass of the write landing at the same edge).
//   - else rf_data.
//   - When s1_valid=0: rsp_valid<=0, rsp_id and rsp_data hold their values.
//   Boundary conditions:
//   - All NREQ valid every cycle: grants rotate 0,1,..,NREQ-1,0, each requester served once per NREQ cycles.
//   - Single requester streaming: granted every cycle, back-to-back responses.
//   - Requester drops req_valid without a grant: legal, no state change.
//   - Reset mid-operation: in-flight requests discarded, no rsp_valid for them; ptr back to NREQ-1.
//   - Indices >= NREQ never granted. Widths: rsp_id zero-extended to IDW.
// TESTING
//   1 Reset, then req_valid=4'b1111, all addr=5'd3, rf_data=32'hA5
//     -> grants 0,1,2,3,0 on consecutive cycles; rsp_id 0,1,2,3 from cycle 3; rsp_data=32'hA5.
//   2 Req 2 only, addr=5'd7, rf_data=32'h1234 -> req_ready=4'b0100 in T, rf_addr=7 in T+1,
//     rsp_valid=1, rsp_id=2, rsp_data=32'h1234 in T+2 only.
//   3 Req 0 addr=0, rf_data=32'hFFFF_FFFF, wr_en=1 wr_addr=0 in T+1 -> rsp_data=32'h0.
//   4 Req 1 addr=5'd9, wr_en=1 wr_addr=9 wr_data=32'hDEAD_BEEF in T+1, rf_data=32'h0
//     -> rsp_data=32'hDEAD_BEEF; same with wr_addr=8 -> rsp_data=32'h0.
//   5 Requesters 1 and 3 held valid for 6 cycles -> grants alternate 1,3,1,3,1,3;
//     6 rsp pulses, no gaps.
//   6 Grant in T, rst_n=0 in T+1 -> rsp_valid stays 0 through T+3;
//     first grant after release goes to the lowest valid index.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Two-stage pipeline: grant/address register, then data select with x0 and write bypass.
module regfile_read_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        rf_addr,
  input  logic [31:0]       rf_data,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [31:0]       wr_data,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              busy
);

  // Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i];
  // the requester holds req_valid and its address until then. req_ready is a
  // combinational one-hot grant, and responses carry no backpressure.

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           s1_valid_q, s1_valid_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic [4:0]     rf_addr_q, rf_addr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_data_q, rsp_data_d;

  logic           hi_found, lo_found;
  logic [IDW-1:0] hi_idx, lo_idx;
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [4:0]     grant_addr;
  logic [31:0]    sel_data;

  // Rotating priority: first valid index above ptr wins, otherwise wrap to lowest valid.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
      end
      if (req_valid[i] && !hi_found && (IDW'(i) > ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = IDW'(i);
      end
    end
    grant_any = rst_n && lo_found;
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    req_ready  = '0;
    grant_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        req_ready[i] = grant_any;
        grant_addr   = req_addr[5*i +: 5];
      end
    end
  end

  // x0 always reads zero, even against a write to x0; otherwise a write landing
  // at this edge overrides the stale register-file value.
  always_comb begin
    if (rf_addr_q == 5'd0) begin
      sel_data = 32'h0;
    end else if (wr_en && (wr_addr == rf_addr_q)) begin
      sel_data = wr_data;
    end else begin
      sel_data = rf_data;
    end
  end

  always_comb begin
    ptr_d       = grant_any ? grant_idx : ptr_q;
    s1_valid_d  = grant_any;
    s1_id_d     = grant_any ? grant_idx : s1_id_q;
    rf_addr_d   = grant_any ? grant_addr : rf_addr_q;
    rsp_valid_d = s1_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (s1_valid_q) begin
      rsp_id_d   = s1_id_q;
      rsp_data_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= IDW'(NREQ - 1);
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      rf_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      rf_addr_q   <= rf_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rf_addr   = rf_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: arbitration order, pipeline latency,
// x0 forcing, write bypass and mid-flight reset.
module tb_regfile_read_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [19:0]     req_addr = '0;
  logic [NREQ-1:0] req_ready;
  logic [4:0]      rf_addr;
  logic [31:0]     rf_data;
  logic            wr_en = 1'b0;
  logic [4:0]      wr_addr = '0;
  logic [31:0]     wr_data = '0;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_data;
  logic            busy;

  logic            use_model = 1'b0;
  logic [31:0]     rf_data_drv = '0;

  int checks = 0;
  int errors = 0;

  regfile_read_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rf_addr(rf_addr), .rf_data(rf_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register-file model: register r holds 0x1000 + r.
  always_comb begin
    rf_data = rf_data_drv;
    if (use_model) rf_data = 32'h1000 + {27'h0, rf_addr};
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    wr_en = 1'b0;
    use_model = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_addr = {5'd3, 5'd3, 5'd3, 5'd3};
    next_cycle();
    next_cycle();
    settle();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'h0 || rf_addr !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b id=%0d d=%h a=%0d busy=%b expected all zero", rsp_valid, rsp_id, rsp_data, rf_addr, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req_addr = {5'd3, 5'd3, 5'd3, 5'd3};
    rf_data_drv = 32'hA5;
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      settle();
      checks++;
      if (req_ready !== ((c < 5) ? exp_g[c] : 4'b0000)) begin
        errors++; $display("FAIL rr_grant c%0d: got %b", c, req_ready);
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id[c-2] || rsp_data !== 32'hA5) begin
          errors++; $display("FAIL rr_rsp c%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=a5", c, rsp_valid, rsp_id, rsp_data, exp_id[c-2]);
        end
      end else begin
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_idle c%0d: rsp_valid=%b expected 0", c, rsp_valid); end
      end
      next_cycle();
    end
    settle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    req_addr = '0;
    req_addr[14:10] = 5'd7;
    rf_data_drv = 32'h1234;
    req_valid = 4'b0100;
    settle();
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
    next_cycle();
    req_valid = '0;
    settle();
    checks++;
    if (rf_addr !== 5'd7 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_s1: got a=%0d v=%b busy=%b expected a=7 v=0 busy=1", rf_addr, rsp_valid, busy);
    end
    next_cycle();
    settle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h1234) begin
      errors++; $display("FAIL single_rsp: got v=%b id=%0d d=%h expected v=1 id=2 d=1234", rsp_valid, rsp_id, rsp_data);
    end
    next_cycle();
    settle();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h1234 || busy !== 1'b0) begin
      errors++; $display("FAIL single_after: got v=%b d=%h busy=%b expected v=0 d=1234 busy=0", rsp_valid, rsp_data, busy);
    end
  endtask

  task automatic test_zero_reg();
    req_addr = '0;
    req_valid = 4'b0001;
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL zero_grant: got %b expected 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    rf_data_drv = 32'hFFFF_FFFF;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    next_cycle();
    wr_en = 1'b0;
    settle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL zero_rsp: got v=%b id=%0d d=%h expected v=1 id=0 d=0", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_bypass();
    logic [4:0] waddr [2] = '{5'd9, 5'd8};
    logic [31:0] exp_d [2] = '{32'hDEAD_BEEF, 32'h0};
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      req_addr = '0;
      req_addr[9:5] = 5'd9;
      req_valid = 4'b0010;
      settle();
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL bypass_grant%0d: got %b expected 0010", k, req_ready); end
      next_cycle();
      req_valid = '0;
      rf_data_drv = 32'h0;
      wr_en = 1'b1; wr_addr = waddr[k]; wr_data = 32'hDEAD_BEEF;
      next_cycle();
      wr_en = 1'b0;
      settle();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== exp_d[k]) begin
        errors++; $display("FAIL bypass_rsp%0d: got v=%b id=%0d d=%h expected v=1 id=1 d=%h", k, rsp_valid, rsp_id, rsp_data, exp_d[k]);
      end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    use_model = 1'b1;
    req_addr = '0;
    req_addr[9:5] = 5'd5;
    req_addr[19:15] = 5'd6;
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'b1010 : 4'b0000;
      settle();
      checks++;
      if (req_ready !== ((c >= 6) ? 4'b0000 : ((c % 2 == 0) ? 4'b0010 : 4'b1000))) begin
        errors++; $display("FAIL alt_grant c%0d: got %b", c, req_ready);
      end
      if (c >= 2 && c <= 7) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== ((c % 2 == 0) ? 2'd1 : 2'd3) ||
            rsp_data !== ((c % 2 == 0) ? 32'h1005 : 32'h1006)) begin
          errors++; $display("FAIL alt_rsp c%0d: got v=%b id=%0d d=%h", c, rsp_valid, rsp_id, rsp_data);
        end
      end
      next_cycle();
    end
    settle();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL alt_end: rsp_valid=%b expected 0", rsp_valid); end
    use_model = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    use_model = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 4'b0100 : 4'b0000;
      req_addr = '0;
      req_addr[14:10] = 5'(10 + c);
      settle();
      checks++;
      if (req_ready !== ((c < 4) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL b2b_grant c%0d: got %b", c, req_ready); end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h1000 + 32'(10 + c - 2)) begin
          errors++; $display("FAIL b2b_rsp c%0d: got v=%b id=%0d d=%h expected v=1 id=2 d=%h", c, rsp_valid, rsp_id, rsp_data, 32'h1000 + 32'(10 + c - 2));
        end
      end
      next_cycle();
    end
    use_model = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rf_data_drv = 32'h55;
    req_addr = {5'd4, 5'd4, 5'd4, 5'd4};
    req_valid = 4'b0100;
    settle();
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant: got %b expected 0100", req_ready); end
    next_cycle();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    settle();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready: got %b expected 0000", req_ready); end
    next_cycle();
    rst_n = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rmid_flush c%0d: got v=%b busy=%b expected 0 0", c, rsp_valid, busy);
      end
      next_cycle();
    end
    req_valid = 4'b1100;
    settle();
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_regrant: got %b expected 0100", req_ready); end
    next_cycle();
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_reg();
    test_bypass();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
